// File: rtl/counter_scan_ctrl_pkg.sv
// Shared types and constants for the scan-test sequencer.
package counter_scan_ctrl_pkg;

    localparam int unsigned CHAIN_LEN = 4;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Test parameters latched when a start is accepted.
    typedef struct packed {
        logic                 capture_dir;
        logic [CHAIN_LEN-1:0] expected;
    } scan_cfg_t;

endpackage

// File: rtl/counter_scan_ctrl_if.sv
// Register-side request/result signals plus the counter's scan pins.
interface counter_scan_ctrl_if;

    logic                                          start;
    logic                                          abort;
    logic [counter_scan_ctrl_pkg::CHAIN_LEN-1:0]   pattern_in;
    logic                                          capture_dir;
    logic [counter_scan_ctrl_pkg::CHAIN_LEN-1:0]   expected;
    logic                                          scan_so;
    logic                                          scan_se;
    logic                                          scan_si;
    logic                                          dut_enable;
    logic                                          dut_count_dir;
    logic                                          dut_reset;
    logic                                          busy;
    logic                                          done;
    logic                                          pass;
    logic [counter_scan_ctrl_pkg::CHAIN_LEN-1:0]   captured;

    // Sequencer side
    modport slave (
        input  start, abort, pattern_in, capture_dir, expected, scan_so,
        output scan_se, scan_si, dut_enable, dut_count_dir, dut_reset,
               busy, done, pass, captured
    );

    // Test host / counter side
    modport master (
        output start, abort, pattern_in, capture_dir, expected, scan_so,
        input  scan_se, scan_si, dut_enable, dut_count_dir, dut_reset,
               busy, done, pass, captured
    );

endinterface

// File: rtl/counter_scan_ctrl_shift_cnt.sv
// Loadable down-counter with zero flag; times the LOAD and UNLOAD phases.
module counter_scan_ctrl_shift_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/counter_scan_ctrl.sv
// Scan-test sequencer: LOAD pattern, CAPTURE one count edge, UNLOAD, compare.
module counter_scan_ctrl
    import counter_scan_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    counter_scan_ctrl_if.slave  bus
);

    state_t               state_q, state_d;
    scan_cfg_t            cfg_q, cfg_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic                 pass_q, pass_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 en_q, en_d;
    logic                 dir_q, dir_d;
    logic                 drst_q, drst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_dec;
    logic                 cnt_zero_c;

    counter_scan_ctrl_shift_cnt #(.CNT_W(CNT_W)) u_shift_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    // Next state and next registered outputs; outputs describe the state being entered.
    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        pat_d        = pat_q;
        cap_d        = cap_q;
        pass_d       = pass_q;
        se_d         = 1'b0;
        si_d         = 1'b0;
        en_d         = 1'b0;
        dir_d        = 1'b0;
        drst_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        if (bus.abort) begin
            // Abort beats start; only the counter reset pulse survives.
            state_d = ST_IDLE;
            drst_d  = 1'b1;
            if (state_q != ST_IDLE) begin
                pass_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        cfg_d.capture_dir = bus.capture_dir;
                        cfg_d.expected    = bus.expected;
                        pat_d             = bus.pattern_in;
                        cap_d             = '0;
                        pass_d            = 1'b0;
                        cnt_load          = 1'b1;
                        cnt_load_val      = CNT_W'(CHAIN_LEN - 1);
                        state_d           = ST_LOAD;
                        se_d              = 1'b1;
                        si_d              = bus.pattern_in[CHAIN_LEN-1];
                        busy_d            = 1'b1;
                    end
                end
                ST_LOAD: begin
                    busy_d = 1'b1;
                    if (cnt_zero_c) begin
                        state_d = ST_CAPTURE;
                        en_d    = 1'b1;
                        dir_d   = cfg_q.capture_dir;
                    end else begin
                        cnt_dec = 1'b1;
                        pat_d   = {pat_q[CHAIN_LEN-2:0], 1'b0};
                        se_d    = 1'b1;
                        si_d    = pat_q[CHAIN_LEN-2];
                    end
                end
                ST_CAPTURE: begin
                    state_d      = ST_UNLOAD;
                    busy_d       = 1'b1;
                    se_d         = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(CHAIN_LEN - 1);
                end
                ST_UNLOAD: begin
                    // Sample scan_so on the same edge the counter shifts.
                    cap_d = {cap_q[CHAIN_LEN-2:0], bus.scan_so};
                    if (cnt_zero_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (cap_d == cfg_q.expected);
                    end else begin
                        cnt_dec = 1'b1;
                        busy_d  = 1'b1;
                        se_d    = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            pat_q   <= '0;
            cap_q   <= '0;
            pass_q  <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            en_q    <= 1'b0;
            dir_q   <= 1'b0;
            drst_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            pat_q   <= pat_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            se_q    <= se_d;
            si_q    <= si_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
            drst_q  <= drst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.scan_se       = se_q;
    assign bus.scan_si       = si_q;
    assign bus.dut_enable    = en_q;
    assign bus.dut_count_dir = dir_q;
    assign bus.dut_reset     = drst_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.captured      = cap_q;

endmodule
